dmem_sram_bridge: RTL and testbench

// - Sits directly downstream of the datapath MEM stage: turns the one-cycle-level mem_en/mem_we/sel/mem_size request

---
 rtl/dmem_sram_bridge_pkg.sv | 25 ++
 rtl/dmem_sram_bridge_if.sv | 52 +++++
 rtl/dmem_sram_bridge.sv | 123 ++++++++++++
 tb/tb_dmem_sram_bridge.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_sram_bridge_pkg.sv
// -----------------------------------------------------------------------------
// dmem_sram_bridge_pkg
// Shared types for the MEM-stage to SRAM-like data bus bridge:
//   - dmem_state_e : bridge FSM state encodings (2 bits)
//   - SIZE_*       : mem_size / data_size encodings
//   - wstrb_for()  : byte strobes presented on the bus (reads carry no strobes)
// -----------------------------------------------------------------------------
package dmem_sram_bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } dmem_state_e;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    function automatic logic [3:0] wstrb_for(input logic we, input logic [3:0] sel);
        return we ? sel : 4'b0000;
    endfunction

endpackage

// File: rtl/dmem_sram_bridge_if.sv
// -----------------------------------------------------------------------------
// dmem_sram_bridge_if
// SRAM-like data bus between the MEM-stage bridge (master) and the data
// cache / AXI bridge (slave).
//   data_req      master->slave  request valid
//   data_wr       master->slave  1 = write
//   data_size     master->slave  0 byte, 1 half, 2 word
//   data_addr     master->slave  byte address
//   data_wstrb    master->slave  byte strobes (0 on reads)
//   data_wdata    master->slave  store data
//   data_addr_ok  slave->master  address phase accepted this cycle
//   data_data_ok  slave->master  data phase complete this cycle
//   data_rdata    slave->master  read data, valid with data_data_ok
// -----------------------------------------------------------------------------
interface dmem_sram_bridge_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              data_req;
    logic              data_wr;
    logic [1:0]        data_size;
    logic [ADDR_W-1:0] data_addr;
    logic [3:0]        data_wstrb;
    logic [DATA_W-1:0] data_wdata;
    logic              data_addr_ok;
    logic              data_data_ok;
    logic [DATA_W-1:0] data_rdata;

    modport master (
        output data_req,
        output data_wr,
        output data_size,
        output data_addr,
        output data_wstrb,
        output data_wdata,
        input  data_addr_ok,
        input  data_data_ok,
        input  data_rdata
    );

    modport slave (
        input  data_req,
        input  data_wr,
        input  data_size,
        input  data_addr,
        input  data_wstrb,
        input  data_wdata,
        output data_addr_ok,
        output data_data_ok,
        output data_rdata
    );
endinterface

// File: rtl/dmem_sram_bridge.sv
// -----------------------------------------------------------------------------
// dmem_sram_bridge
// Converts the level-style MEM-stage access (mem_en/mem_we/sel/mem_size) into a
// single SRAM-like req/addr_ok/data_ok transaction, stalls the pipeline until
// the data phase completes and holds the returned data while the pipeline
// stays frozen by other stall sources.
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous, active-low reset
//   mem_en      MEM-stage access request (already flush-gated upstream)
//   mem_we      1 = store, 0 = load
//   mem_size    0 byte, 1 half, 2 word
//   mem_addr    byte address
//   mem_wdata   lane-aligned store data
//   sel         store byte enables
//   pipe_stall  pipeline hold from other sources (excludes our stallreq)
//   mem_rdata   load data to MEM stage
//   stallreq    stall request to the hazard unit
//   bus         SRAM-like data bus (master side)
//
// Configuration
//   DMEM_SRAM_BRIDGE_RDATA_BYPASS_EN : when defined, load data is forwarded
//   combinationally in the data_ok cycle and the stall drops in that cycle.
//
// State table
//   state | meaning
//   IDLE  | no transaction; a MEM request is issued from here
//   REQ   | request presented, waiting for addr_ok (never withdrawn)
//   WAIT  | address accepted, waiting for data_ok
//   DONE  | data captured, pipeline still held elsewhere; no re-issue
// -----------------------------------------------------------------------------
module dmem_sram_bridge
    import dmem_sram_bridge_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_en,
    input  logic              mem_we,
    input  logic [1:0]        mem_size,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic [3:0]        sel,
    input  logic              pipe_stall,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              stallreq,
    dmem_sram_bridge_if.master bus
);

    dmem_state_e       state_q, state_d;
    logic [DATA_W-1:0] rdata_buf_q, rdata_buf_d;
    logic              data_req;

    // Address phase fields follow the MEM stage directly.
    assign bus.data_req   = data_req;
    assign bus.data_wr    = mem_we;
    assign bus.data_size  = mem_size;
    assign bus.data_addr  = mem_addr;
    assign bus.data_wstrb = wstrb_for(mem_we, sel);
    assign bus.data_wdata = mem_wdata;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            rdata_buf_q <= '0;
        end else begin
            state_q     <= state_d;
            rdata_buf_q <= rdata_buf_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        rdata_buf_d = rdata_buf_q;
        data_req    = 1'b0;
        stallreq    = 1'b0;
        mem_rdata   = rdata_buf_q;

        case (state_q)
            ST_IDLE: begin
                // Late handshakes after a reset land here and are ignored.
                if (mem_en) begin
                    data_req = 1'b1;
                    stallreq = 1'b1;
                    state_d  = bus.data_addr_ok ? ST_WAIT : ST_REQ;
                end
            end
            ST_REQ: begin
                data_req = 1'b1;
                stallreq = 1'b1;
                if (bus.data_addr_ok) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                stallreq = 1'b1;
                if (bus.data_data_ok) begin
                    // Captured for stores too, so the buffer always reflects
                    // the last completed transaction.
                    rdata_buf_d = bus.data_rdata;
                    state_d     = pipe_stall ? ST_DONE : ST_IDLE;
`ifdef DMEM_SRAM_BRIDGE_RDATA_BYPASS_EN
                    stallreq    = 1'b0;
                    mem_rdata   = bus.data_rdata;
`endif
                end
            end
            ST_DONE: begin
                // Same instruction still sits in MEM: hold data, do not re-issue.
                if (!pipe_stall) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_dmem_sram_bridge.sv
module tb_dmem_sram_bridge;
    import dmem_sram_bridge_pkg::*;

    logic        clk;
    logic        rst;
    logic        mem_en;
    logic        mem_we;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  sel;
    logic        pipe_stall;
    logic [31:0] mem_rdata;
    logic        stallreq;

    int n_chk;
    int n_fail;
    int req_cnt;
    int stall_cnt;

    dmem_sram_bridge_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    dmem_sram_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_size   (mem_size),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .sel        (sel),
        .pipe_stall (pipe_stall),
        .mem_rdata  (mem_rdata),
        .stallreq   (stallreq),
        .bus        (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef DMEM_SRAM_BRIDGE_RDATA_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Sample at the falling edge; inputs change 1ns after the rising edge.
    task automatic smp();
        @(negedge clk);
        if (bus.data_req === 1'b1) req_cnt++;
        if (stallreq === 1'b1) stall_cnt++;
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        mem_en = 0; mem_we = 0; mem_size = SIZE_WORD; mem_addr = '0;
        mem_wdata = '0; sel = 4'h0; pipe_stall = 0;
        bus.data_addr_ok = 0; bus.data_data_ok = 0; bus.data_rdata = '0;
    endtask

    initial begin
        n_chk = 0; n_fail = 0; req_cnt = 0; stall_cnt = 0;
        rst = 0;
        idle_inputs();

        // ---------------- reset state ----------------
        adv(); smp();
        chk("rst_state", 64'(dut.state_q), 64'(ST_IDLE));
        chk("rst_req", 64'(bus.data_req), 64'd0);
        chk("rst_stall", 64'(stallreq), 64'd0);
        chk("rst_rdata", 64'(mem_rdata), 64'd0);
        chk("rst_wstrb", 64'(bus.data_wstrb), 64'd0);
        adv(); rst = 1;
        adv();

        // ---------------- 1: word load, addr_ok immediately, data_ok 2 later ----------------
        req_cnt = 0; stall_cnt = 0;
        mem_en = 1; mem_we = 0; mem_size = SIZE_WORD; mem_addr = 32'h0000_0100; sel = 4'hF;
        bus.data_addr_ok = 1;
        smp();
        chk("ld1_req_c0", 64'(bus.data_req), 64'd1);
        chk("ld1_wr_c0", 64'(bus.data_wr), 64'd0);
        chk("ld1_wstrb_c0", 64'(bus.data_wstrb), 64'd0);
        adv(); bus.data_addr_ok = 0;
        smp();
        chk("ld1_req_c1", 64'(bus.data_req), 64'd0);
        chk("ld1_stall_c1", 64'(stallreq), 64'd1);
        adv(); bus.data_data_ok = 1; bus.data_rdata = 32'hDEAD_BEEF;
        smp();
        chk("ld1_stall_c2", 64'(stallreq), BYPASS ? 64'd0 : 64'd1);
        chk("ld1_rdata_c2", 64'(mem_rdata), BYPASS ? 64'hDEAD_BEEF : 64'd0);
        adv(); bus.data_data_ok = 0; bus.data_rdata = 32'h1234_5678; mem_en = 0;
        smp();
        chk("ld1_rdata_c3", 64'(mem_rdata), 64'hDEAD_BEEF);
        chk("ld1_stall_c3", 64'(stallreq), 64'd0);
        chk("ld1_req_cycles", 64'(req_cnt), 64'd1);
        chk("ld1_stall_cycles", 64'(stall_cnt), BYPASS ? 64'd2 : 64'd3);
        adv();

        // ---------------- 2: store word, addr_ok delayed 3 cycles ----------------
        req_cnt = 0; stall_cnt = 0;
        mem_en = 1; mem_we = 1; mem_size = SIZE_WORD; mem_addr = 32'h8000_0010;
        mem_wdata = 32'hCAFE_F00D; sel = 4'hF;
        smp(); adv();
        smp(); adv();
        smp();
        chk("st_req_c2", 64'(bus.data_req), 64'd1);
        adv(); bus.data_addr_ok = 1;
        smp();
        chk("st_req_c3", 64'(bus.data_req), 64'd1);
        chk("st_addr", 64'(bus.data_addr), 64'h8000_0010);
        chk("st_wdata", 64'(bus.data_wdata), 64'hCAFE_F00D);
        chk("st_wstrb", 64'(bus.data_wstrb), 64'hF);
        chk("st_wr", 64'(bus.data_wr), 64'd1);
        adv(); bus.data_addr_ok = 0; bus.data_data_ok = 1; bus.data_rdata = 32'h1111_2222;
        smp();
        chk("st_req_c4", 64'(bus.data_req), 64'd0);
        adv(); bus.data_data_ok = 0; mem_en = 0; mem_we = 0;
        smp();
        chk("st_req_cycles", 64'(req_cnt), 64'd4);
        chk("st_stall_cycles", 64'(stall_cnt), BYPASS ? 64'd4 : 64'd5);
        chk("st_buf_capture", 64'(mem_rdata), 64'h1111_2222);
        adv();

        // ---------------- 3: load completes under pipe_stall ----------------
        req_cnt = 0;
        mem_en = 1; mem_we = 0; mem_addr = 32'h0000_0200; bus.data_addr_ok = 1;
        smp(); adv();
        bus.data_addr_ok = 0; bus.data_data_ok = 1; bus.data_rdata = 32'hA5A5_5A5A; pipe_stall = 1;
        smp(); adv();
        bus.data_data_ok = 0; bus.data_rdata = 32'hFFFF_FFFF;
        for (int i = 0; i < 5; i++) begin
            smp();
            chk($sformatf("done_state_%0d", i), 64'(dut.state_q), 64'(ST_DONE));
            chk($sformatf("done_stall_%0d", i), 64'(stallreq), 64'd0);
            chk($sformatf("done_rdata_%0d", i), 64'(mem_rdata), 64'hA5A5_5A5A);
            adv();
        end
        pipe_stall = 0;
        smp();
        chk("done_release_req", 64'(bus.data_req), 64'd0);
        adv(); mem_en = 0;
        smp();
        chk("done_back_idle", 64'(dut.state_q), 64'(ST_IDLE));
        chk("done_req_cycles", 64'(req_cnt), 64'd1);
        adv();

        // ---------------- 4: byte load at offset 3 ----------------
        mem_en = 1; mem_we = 0; mem_size = SIZE_BYTE; mem_addr = 32'h0000_1003; sel = 4'h8;
        bus.data_addr_ok = 1;
        smp();
        chk("byte_size", 64'(bus.data_size), 64'(SIZE_BYTE));
        chk("byte_addr_lo", 64'(bus.data_addr[1:0]), 64'd3);
        chk("byte_wstrb", 64'(bus.data_wstrb), 64'd0);
        adv(); bus.data_addr_ok = 0; bus.data_data_ok = 1; bus.data_rdata = 32'h0000_00EF;
        smp(); adv();
        bus.data_data_ok = 0; mem_en = 0; mem_size = SIZE_WORD;
        smp();
        chk("byte_rdata", 64'(mem_rdata), 64'h0000_00EF);
        adv();

        // ---------------- 5: reset while in WAIT, late data_ok ----------------
        mem_en = 1; mem_addr = 32'h0000_0300; bus.data_addr_ok = 1;
        smp(); adv();
        bus.data_addr_ok = 0;
        smp();
        chk("rw_stall_wait", 64'(stallreq), 64'd1);
        adv();
        rst = 0; idle_inputs();
        smp();
        chk("rw_state", 64'(dut.state_q), 64'(ST_IDLE));
        chk("rw_rdata_cleared", 64'(mem_rdata), 64'd0);
        adv(); rst = 1;
        adv(); bus.data_data_ok = 1; bus.data_rdata = 32'h7777_7777;
        smp();
        chk("rw_late_stall", 64'(stallreq), 64'd0);
        chk("rw_late_req", 64'(bus.data_req), 64'd0);
        adv(); bus.data_data_ok = 0;
        smp();
        chk("rw_no_capture", 64'(mem_rdata), 64'd0);
        chk("rw_state_after", 64'(dut.state_q), 64'(ST_IDLE));
        adv();

        // ---------------- 6: back-to-back loads ----------------
        req_cnt = 0;
        mem_en = 1; mem_addr = 32'h0000_0400; bus.data_addr_ok = 1;
        smp(); adv();
        bus.data_addr_ok = 0; bus.data_data_ok = 1; bus.data_rdata = 32'h1111_1111;
        smp();
        chk("b2b_first_req_off", 64'(bus.data_req), 64'd0);
        if (BYPASS) chk("b2b_bypass_rdata", 64'(mem_rdata), 64'h1111_1111);
        adv(); bus.data_data_ok = 0; mem_addr = 32'h0000_0404; bus.data_addr_ok = 1;
        smp();
        chk("b2b_second_req", 64'(bus.data_req), 64'd1);
        chk("b2b_second_addr", 64'(bus.data_addr), 64'h0000_0404);
        chk("b2b_first_rdata", 64'(mem_rdata), 64'h1111_1111);
        adv(); bus.data_addr_ok = 0; bus.data_data_ok = 1; bus.data_rdata = 32'h2222_2222;
        smp(); adv();
        bus.data_data_ok = 0; mem_en = 0;
        smp();
        chk("b2b_second_rdata", 64'(mem_rdata), 64'h2222_2222);
        chk("b2b_req_cycles", 64'(req_cnt), 64'd2);
        adv();

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
